seg7_decode_monitor: RTL and testbench
======================================

Name: seg7_decode_monitor

Overview:
Receive-side checker for the seven-segment digit display bus. It samples a 7-bit segment pattern, filters glitches, and decodes the pattern back to a BCD digit. It checks that digits advance 0..9 with wrap-around and measures the cycle period between digit changes. It is used for on-chip self-test of the display path, wired to the segment outputs, and also as a reusable bench monitor.

Parameters:
STABLE_CYCLES, 4, consecutive cycles a registered pattern must hold before it is accepted (legal range 1..15)
PERIOD_W, 24, width of the period counter and period output

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
segments_in  input  7  segment pattern; bit0 = seg1 (top) .. bit6 = seg7 (middle)
digit_out  output  4  last accepted valid digit
digit_valid  output  1  high once any valid digit has been accepted
digit_strobe  output  1  one-cycle pulse when a new valid digit is accepted
period  output  PERIOD_W  clock cycles between the last two valid accepts
period_valid  output  1  high once period holds a measurement
locked  output  1  high while the FSM is in TRACK
seq_error  output  1  sticky; a digit arrived out of sequence
bad_pattern  output  1  sticky; a non-digit, non-blank pattern was accepted
error_count  output  8  saturating count of seq and pattern errors

Behaviour:
- Reset (synchronous) clears every output and all internal state to 0. FSM goes to ACQUIRE. Reset mid-operation has the same effect; outputs read 0 in the cycle after reset is sampled.
- Input stage: segments_in is registered into seg_q every cycle.
- Stability filter: stab_cnt resets to 0 when seg_q differs from its previous value, otherwise increments, saturating at STABLE_CYCLES.
- Accept: when stab_cnt reaches STABLE_CYCLES-1 and seg_q differs from acc_pat, acc_pat is loaded with seg_q.
- Latency: for a clean change, digit_strobe is high exactly STABLE_CYCLES+1 cycles after the edge that first presents the new pattern on segments_in. Pulses shorter than STABLE_CYCLES cycles produce no accept.
- Decode: valid patterns are 0:0111111, 1:0000110, 2:1011011, 3:1001111, 4:1100110, 5:1101101, 6:1111100, 7:0000111, 8:1111111, 9:1100111.
  - Blank 0000000: accepted silently. No strobe, no error, digit_out unchanged, FSM unchanged.
  - Any other pattern: bad_pattern<=1, error_count+1, no strobe, digit_out and FSM unchanged.
- Period counter cnt (PERIOD_W bits):
  - Set to 1 on a valid accept, else increments, saturating at all-ones.
  - On a valid accept in SYNC or TRACK: period<=cnt, period_valid<=1.
  - Accept wins over saturation when both occur in the same cycle.
- FSM on each valid accept (digit d, previous digit p):
  - ACQUIRE -> SYNC. Load digit_out, set digit_valid. No sequence check, no period update.
  - SYNC -> TRACK if d==(p+1) mod 10. Otherwise stay in SYNC with a seq error.
  - TRACK -> TRACK if d==(p+1) mod 10. Otherwise go to SYNC with a seq error.
  - A seq error sets seq_error<=1 and increments error_count. digit_out still takes d, which becomes the new reference.
- Wrap: 9 -> 0 is in sequence. A repeat of the same digit cannot occur, because acc_pat must change for an accept.
- error_count saturates at 255. seq and pattern errors cannot coincide, since there is at most one accept per cycle.
- locked = (state==TRACK), registered.

Decomposition:
- Shared package seg7_pkg: the ten segment pattern constants, the BLANK constant, and the FSM state enum (ACQUIRE, SYNC, TRACK).
- One sub-module, seg7_decode: purely combinational, pattern[6:0] -> {is_digit, is_blank, digit[3:0]}.
- Filter, period counter and FSM stay in seg7_decode_monitor.

Test Plan:
1. Reset, then hold 0111111 with STABLE_CYCLES=4 -> digit_strobe high exactly 5 cycles after the input change; digit_out=0, digit_valid=1, locked=0, period_valid=0.
2. Drive 0..9 then 0, each held 100 cycles -> 11 strobes. From the 2nd accept: period=100, period_valid=1, locked=1. After the 9->0 wrap: seq_error=0, error_count=0.
3. While showing 4, pulse the pattern for 5 (1101101) for 2 cycles, then return to 4 -> no strobe; digit_out=4; period counter keeps running (next period reads original+2 glitch-free).
4. In TRACK at 3, drive 5 -> seq_error=1, error_count=1, locked=0, digit_out=5. Then drive 6 -> locked=1, seq_error remains 1.
5. Drive 1010101 for 10 cycles, then 0000000 for 10 cycles -> bad_pattern=1, error_count+1, no strobes, digit_out and locked unchanged.
6. Assert reset for 1 cycle mid-run at digit 7 -> the next cycle shows all outputs 0 and FSM in ACQUIRE. Separately, force 300 bad patterns -> error_count=255.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment receive path: digit patterns and
// the monitor's sequencing states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111100;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1100111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        SYNC    = 2'd1,
        TRACK   = 2'd2
    } mon_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to BCD decoder; flags blank and non-digit
// patterns so the monitor can classify every accepted pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       is_digit,
    output logic       is_blank,
    output logic [3:0] digit
);

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_decode_monitor.sv
// Seven-segment bus checker: glitch filter, digit decode, 0..9 sequence
// tracking and period measurement between digit changes.
//
// state   | meaning
// ACQUIRE | no valid digit seen since reset
// SYNC    | have a reference digit, last step not (yet) in sequence
// TRACK   | last accepted digit followed its predecessor in sequence
module seg7_decode_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          segments_in,
    output logic [3:0]          digit_out,
    output logic                digit_valid,
    output logic                digit_strobe,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                locked,
    output logic                seq_error,
    output logic                bad_pattern,
    output logic [7:0]          error_count
);

    localparam logic [3:0]          STAB_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0]          STAB_ACC = 4'(STABLE_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);

    logic [6:0]          seg_q;
    logic [6:0]          acc_pat;
    logic [3:0]          stab_cnt;
    logic [PERIOD_W-1:0] cnt;
    mon_state_t          state;

    logic       dec_digit;
    logic       dec_blank;
    logic [3:0] dec_val;

    logic       accept;
    logic       acc_digit;
    logic       acc_bad;
    logic       in_seq;
    logic       err_inc;
    logic [3:0] next_digit;

    seg7_decode u_decode (
        .pattern  (seg_q),
        .is_digit (dec_digit),
        .is_blank (dec_blank),
        .digit    (dec_val)
    );

    always_comb begin
        accept     = (stab_cnt == STAB_ACC) && (seg_q != acc_pat);
        acc_digit  = accept && dec_digit;
        acc_bad    = accept && !dec_digit && !dec_blank;
        next_digit = (digit_out == 4'd9) ? 4'd0 : digit_out + 4'd1;
        in_seq     = (dec_val == next_digit);
        err_inc    = acc_bad || (acc_digit && (state != ACQUIRE) && !in_seq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q        <= '0;
            acc_pat      <= '0;
            stab_cnt     <= '0;
            cnt          <= '0;
            state        <= ACQUIRE;
            digit_out    <= '0;
            digit_valid  <= 1'b0;
            digit_strobe <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            seq_error    <= 1'b0;
            bad_pattern  <= 1'b0;
            error_count  <= '0;
        end else begin
            seg_q <= segments_in;
            // Counter restarts in the same cycle seg_q takes a new value.
            if (segments_in != seg_q)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + 4'd1;

            if (accept)
                acc_pat <= seg_q;

            digit_strobe <= acc_digit;

            if (acc_digit)
                cnt <= CNT_ONE;
            else if (cnt != '1)
                cnt <= cnt + CNT_ONE;

            if (acc_bad)
                bad_pattern <= 1'b1;

            if (err_inc && (error_count != 8'hFF))
                error_count <= error_count + 8'd1;

            if (acc_digit) begin
                digit_out   <= dec_val;
                digit_valid <= 1'b1;
                case (state)
                    ACQUIRE: begin
                        state  <= SYNC;
                        locked <= 1'b0;
                    end
                    SYNC, TRACK: begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        if (in_seq) begin
                            state  <= TRACK;
                            locked <= 1'b1;
                        end else begin
                            state     <= SYNC;
                            locked    <= 1'b0;
                            seq_error <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Bench for seg7_decode_monitor: directed segments plus random segments,
// every cycle compared against an event-level reference model.
module tb_seg7_decode_monitor;

    localparam int S  = 4;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    segments_in = 7'b0;
    logic [3:0]    digit_out;
    logic          digit_valid;
    logic          digit_strobe;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          seq_error;
    logic          bad_pattern;
    logic [7:0]    error_count;

    seg7_decode_monitor #(.STABLE_CYCLES(S), .PERIOD_W(PW)) dut (
        .clk          (clk),
        .reset        (reset),
        .segments_in  (segments_in),
        .digit_out    (digit_out),
        .digit_valid  (digit_valid),
        .digit_strobe (digit_strobe),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .seq_error    (seq_error),
        .bad_pattern  (bad_pattern),
        .error_count  (error_count)
    );

    always #5 clk = ~clk;

    logic [6:0] digit_pat [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                   7'b1100110, 7'b1101101, 7'b1111100, 7'b0000111,
                                   7'b1111111, 7'b1100111};

    typedef struct {
        int         at;
        logic [6:0] pat;
    } acc_ev_t;

    acc_ev_t    evq [$];
    acc_ev_t    ev;
    int         cyc = 0;
    logic       rst_seen = 1'b0;
    logic [6:0] model_acc = 7'b0;

    int m_digit = 0, m_errs = 0, m_period = 0, m_last_acc = 0, d = 0;
    bit m_dvalid = 0, m_locked = 0, m_seqerr = 0, m_bad = 0, m_pvalid = 0, m_strobe = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int pat_to_digit(logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (digit_pat[i] == p) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    // Reference model: applies each scheduled accept and compares all outputs.
    always @(negedge clk) begin
        m_strobe = 0;
        if (rst_seen) begin
            evq.delete();
            m_digit = 0; m_errs = 0; m_period = 0;
            m_dvalid = 0; m_locked = 0; m_seqerr = 0; m_bad = 0; m_pvalid = 0;
        end else if (evq.size() > 0 && evq[0].at == cyc) begin
            ev = evq.pop_front();
            d = pat_to_digit(ev.pat);
            if (d >= 0) begin
                m_strobe = 1;
                if (m_dvalid) begin
                    m_period = cyc - m_last_acc;
                    m_pvalid = 1;
                    if (d == (m_digit + 1) % 10) m_locked = 1;
                    else begin
                        m_locked = 0;
                        m_seqerr = 1;
                        if (m_errs < 255) m_errs++;
                    end
                end
                m_digit = d;
                m_dvalid = 1;
                m_last_acc = cyc;
            end else if (ev.pat != 7'b0) begin
                m_bad = 1;
                if (m_errs < 255) m_errs++;
            end
        end
        check("digit_strobe", 32'(digit_strobe), 32'(m_strobe));
        check("digit_out",    32'(digit_out),    32'(m_digit));
        check("digit_valid",  32'(digit_valid),  32'(m_dvalid));
        check("period",       32'(period),       32'(m_period));
        check("period_valid", 32'(period_valid), 32'(m_pvalid));
        check("locked",       32'(locked),       32'(m_locked));
        check("seq_error",    32'(seq_error),    32'(m_seqerr));
        check("bad_pattern",  32'(bad_pattern),  32'(m_bad));
        check("error_count",  32'(error_count),  32'(m_errs));
    end

    // Holds pattern p for n sampling edges; schedules an accept if it qualifies.
    task automatic drive(logic [6:0] p, int n);
        @(posedge clk);
        #1;
        segments_in = p;
        if (n >= S && p != model_acc) begin
            evq.push_back(acc_ev_t'{at: cyc + S + 1, pat: p});
            model_acc = p;
        end
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic do_reset(int n);
        @(posedge clk);
        #1;
        reset = 1'b1;
        segments_in = 7'b0;
        model_acc = 7'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int         last_d;
    int         r;
    int         len;
    logic [6:0] p;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Full sequence 0..9 then wrap to 0.
        for (int i = 0; i <= 10; i++) drive(digit_pat[i % 10], 100);
        drive(digit_pat[1], 100);
        drive(digit_pat[2], 100);
        drive(digit_pat[3], 100);
        drive(digit_pat[5], 100);
        drive(digit_pat[6], 100);
        // Short glitch must not be accepted.
        drive(digit_pat[7], 2);
        drive(digit_pat[6], 50);
        drive(7'b1010101, 10);
        drive(7'b0000000, 10);
        drive(digit_pat[7], 60);
        do_reset(1);
        drive(digit_pat[3], 20);
        drive(digit_pat[4], S);
        drive(digit_pat[5], S - 1);
        drive(digit_pat[4], 20);

        // Error counter saturation.
        do_reset(1);
        for (int i = 0; i < 300; i++)
            drive((i % 2 == 0) ? 7'b1010101 : 7'b0101010, S);
        drive(digit_pat[2], 20);

        // Random segments.
        do_reset(2);
        last_d = 0;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                last_d = (last_d + 1) % 10;
                p = digit_pat[last_d];
            end else if (r <= 7) begin
                last_d = $urandom_range(0, 9);
                p = digit_pat[last_d];
            end else if (r == 8) begin
                p = 7'b0;
            end else begin
                p = 7'($urandom_range(0, 127));
            end
            while (p == segments_in) p = 7'($urandom_range(0, 127));
            len = $urandom_range(1, 8);
            drive(p, len);
        end
        drive(7'b0, 20);

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
